// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronises and debounces N push-buttons, produces one-hot
//                single-cycle press pulses (lowest index wins on collision)
//                gated by enable, and keeps a saturating count of forwarded
//                presses.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BOTOES        = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botoes_raw,
    input  logic                enable,
    input  logic                clear_jogadas,
    output logic [N_BOTOES-1:0] botoes_pulso,
    output logic [N_BOTOES-1:0] botoes_estavel,
    output logic [7:0]          jogadas
);

    localparam int                 C_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONF_PRESS  = 2'd1,
        PRESSIONADO = 2'd2,
        CONF_SOLTA  = 2'd3
    } state_t;

    logic [N_BOTOES-1:0] r_sync1;
    logic [N_BOTOES-1:0] r_sync2;
    logic [N_BOTOES-1:0] w_cand;
    logic [N_BOTOES-1:0] w_sel;
    logic [N_BOTOES-1:0] r_pulso;
    logic [7:0]          r_jogadas;

    // Two-flop synchroniser bringing the raw button levels into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= botoes_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_BOTOES; i++) begin : g_btn
        state_t               r_state;
        state_t               w_state_nxt;
        logic [C_CNT_W-1:0]   r_cnt;
        logic [C_CNT_W-1:0]   w_cnt_nxt;
        logic                 w_done;

        // Per-button debounce state and stability counter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= SOLTO;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Debounce transitions; any reversal during a confirm state aborts it,
        // so the next attempt starts counting from zero again.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_done      = 1'b0;
            case (r_state)
                SOLTO: begin
                    if (r_sync2[i]) begin
                        w_state_nxt = CONF_PRESS;
                        w_cnt_nxt   = '0;
                    end
                end
                CONF_PRESS: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt = SOLTO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_LAST) begin
                        w_state_nxt = PRESSIONADO;
                        w_cnt_nxt   = '0;
                        w_done      = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + C_ONE;
                    end
                end
                PRESSIONADO: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt = CONF_SOLTA;
                        w_cnt_nxt   = '0;
                    end
                end
                CONF_SOLTA: begin
                    if (r_sync2[i]) begin
                        w_state_nxt = PRESSIONADO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_LAST) begin
                        w_state_nxt = SOLTO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + C_ONE;
                    end
                end
                default: begin
                    w_state_nxt = SOLTO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_cand[i]         = w_done;
        assign botoes_estavel[i] = (r_state == PRESSIONADO) || (r_state == CONF_SOLTA);
    end

    // Isolate the lowest set candidate bit; simultaneous others are dropped.
    assign w_sel = w_cand & (~w_cand + N_BOTOES'(1));

    // Registered pulse output and saturating press counter (clear has priority).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulso   <= '0;
            r_jogadas <= '0;
        end else begin
            r_pulso <= enable ? w_sel : '0;
            if (clear_jogadas) begin
                r_jogadas <= '0;
            end else if (enable && (|w_sel) && (r_jogadas != 8'hFF)) begin
                r_jogadas <= r_jogadas + 8'd1;
            end
        end
    end

    assign botoes_pulso = r_pulso;
    assign jogadas      = r_jogadas;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed, table-driven checks of button_conditioner with a
//                short debounce window, plus hand sequences for saturation,
//                clear, and reset corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] botoes_raw = '0;
    logic         enable = 1'b1;
    logic         clear_jogadas = 1'b0;
    logic [N-1:0] botoes_pulso;
    logic [N-1:0] botoes_estavel;
    logic [7:0]   jogadas;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       do_rst;
        logic [7:0] raw;
        logic       en;
        logic       clr;
        logic [7:0] exp_p;
        logic [7:0] exp_e;
        logic [7:0] exp_j;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .N_BOTOES        (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .botoes_raw     (botoes_raw),
        .enable         (enable),
        .clear_jogadas  (clear_jogadas),
        .botoes_pulso   (botoes_pulso),
        .botoes_estavel (botoes_estavel),
        .jogadas        (jogadas)
    );

    always #5 clk = ~clk;

    // Hard stop in case something stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] raw, input logic en, input logic clr,
                       input logic [7:0] p, input logic [7:0] e, input logic [7:0] j);
        vec_t v;
        v.do_rst = r; v.raw = raw; v.en = en; v.clr = clr;
        v.exp_p = p; v.exp_e = e; v.exp_j = j;
        vecs.push_back(v);
    endtask

    // One clock edge, then settle to a point well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string name);
        rst = 1'b1;
        #2;
        chk({name, "_pulso"},   botoes_pulso,   8'h00);
        chk({name, "_estavel"}, botoes_estavel, 8'h00);
        chk({name, "_jogadas"}, jogadas,        8'h00);
        rst = 1'b0;
    endtask

    // Clean press and full release of one button; pulse expected after edge D+3.
    task automatic press_once(input int b);
        botoes_raw = '0;
        botoes_raw[b] = 1'b1;
        repeat (D + 2) step();
        step();
        chk("press_pulse", botoes_pulso, 8'(1 << b));
        botoes_raw = '0;
        repeat (D + 3) step();
    endtask

    initial begin
        // Clean press of bit 2, then release (no pulse on release).
        for (int k = 1; k <= 6; k++) add(0, 8'h04, 1, 0, 8'h00, 8'h00, 8'd0);
        add(0, 8'h04, 1, 0, 8'h04, 8'h04, 8'd1);
        add(0, 8'h04, 1, 0, 8'h00, 8'h04, 8'd1);
        add(0, 8'h04, 1, 0, 8'h00, 8'h04, 8'd1);
        for (int k = 10; k <= 15; k++) add(0, 8'h00, 1, 0, 8'h00, 8'h04, 8'd1);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 8'd1);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 8'd1);
        // Bounce on bit 0: 1,0,1 then held; pulse timed from the final rise.
        add(1, 8'h01, 1, 0, 8'h00, 8'h00, 8'd0);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 8'd0);
        for (int k = 3; k <= 8; k++) add(0, 8'h01, 1, 0, 8'h00, 8'h00, 8'd0);
        add(0, 8'h01, 1, 0, 8'h01, 8'h01, 8'd1);
        add(0, 8'h01, 1, 0, 8'h00, 8'h01, 8'd1);
        add(0, 8'h01, 1, 0, 8'h00, 8'h01, 8'd1);
        // Simultaneous rise of bits 5 and 1: only bit 1 forwarded.
        add(1, 8'h22, 1, 0, 8'h00, 8'h00, 8'd0);
        for (int k = 2; k <= 6; k++) add(0, 8'h22, 1, 0, 8'h00, 8'h00, 8'd0);
        add(0, 8'h22, 1, 0, 8'h02, 8'h22, 8'd1);
        add(0, 8'h22, 1, 0, 8'h00, 8'h22, 8'd1);
        add(0, 8'h22, 1, 0, 8'h00, 8'h22, 8'd1);
        // Bit 3 press completes while disabled; re-enabling while held gives nothing.
        for (int k = 1; k <= 6; k++) add(0, 8'h08, 0, 0, 8'h00, 8'h22, 8'd1);
        add(0, 8'h08, 0, 0, 8'h00, 8'h08, 8'd1);
        for (int k = 8; k <= 10; k++) add(0, 8'h08, 1, 0, 8'h00, 8'h08, 8'd1);

        // Reset state.
        #2;
        chk("reset_pulso",   botoes_pulso,   8'h00);
        chk("reset_estavel", botoes_estavel, 8'h00);
        chk("reset_jogadas", jogadas,        8'h00);
        step();
        rst = 1'b0;

        foreach (vecs[k]) begin
            if (vecs[k].do_rst) pulse_reset($sformatf("vec%0d_rst", k));
            botoes_raw    = vecs[k].raw;
            enable        = vecs[k].en;
            clear_jogadas = vecs[k].clr;
            step();
            chk($sformatf("vec%0d_pulso", k),   botoes_pulso,   vecs[k].exp_p);
            chk($sformatf("vec%0d_estavel", k), botoes_estavel, vecs[k].exp_e);
            chk($sformatf("vec%0d_jogadas", k), jogadas,        vecs[k].exp_j);
        end

        // Saturation: 256 presses reach 255, one more stays at 255.
        enable = 1'b1;
        botoes_raw = '0;
        pulse_reset("sat_rst");
        repeat (254) press_once(0);
        chk("sat_254", jogadas, 8'd254);
        press_once(0);
        chk("sat_255", jogadas, 8'd255);
        press_once(0);
        chk("sat_hold", jogadas, 8'd255);

        // Clear coincident with a forwarded pulse wins.
        botoes_raw = 8'h01;
        repeat (D + 2) step();
        clear_jogadas = 1'b1;
        step();
        chk("clr_pulso",   botoes_pulso, 8'h01);
        chk("clr_jogadas", jogadas,      8'd0);
        clear_jogadas = 1'b0;
        step();
        chk("clr_after_pulso",   botoes_pulso, 8'h00);
        chk("clr_after_jogadas", jogadas,      8'd0);
        botoes_raw = '0;
        repeat (D + 3) step();
        press_once(0);
        chk("clr_then_count", jogadas, 8'd1);

        // Reset with bit 0 held at cnt==2; treated as a fresh press afterwards.
        botoes_raw = 8'h01;
        repeat (5) step();
        chk("midconf_jog_before", jogadas, 8'd1);
        pulse_reset("midconf_rst");
        repeat (D + 2) step();
        chk("midconf_no_early", botoes_pulso, 8'h00);
        step();
        chk("midconf_pulso",   botoes_pulso,   8'h01);
        chk("midconf_estavel", botoes_estavel, 8'h01);
        chk("midconf_jogadas", jogadas,        8'd1);
        // Reset while the pulse is high aborts it.
        pulse_reset("inflight_rst");
        step();
        chk("inflight_after", botoes_pulso, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BOTOES, default 8, number of physical buttons.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable-sample cycles required (1 ms at 50 MHz); legal range 2..2^20.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port botoes_raw  input  N_BOTOES  asynchronous, bouncy button levels, 1 = pressed.
REQ-006 SHALL have port enable  input  1  1 = pulses forwarded to the matrix controller; 0 = pulses suppressed.
REQ-007 SHALL have port clear_jogadas  input  1  synchronous clear of the move counter.
REQ-008 SHALL have port botoes_pulso  output  N_BOTOES  one-hot single-cycle press pulses, feeding the matrix controller's botoes input.
REQ-009 SHALL have port botoes_estavel  output  N_BOTOES  debounced level of each button.
REQ-010 SHALL have port jogadas  output  8  saturating count of forwarded presses.

Function
REQ-011 SHALL pass each botoes_raw bit through a 2-flop synchronizer; s[i] denotes the second flop.
REQ-012 SHALL run one independent FSM per button with states SOLTO, CONF_PRESS, PRESSIONADO, CONF_SOLTA and a per-button counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 SHALL transition SOLTO->CONF_PRESS with cnt=0 when s[i]=1; otherwise stay.
REQ-014 SHALL in CONF_PRESS: if s[i]=0 return to SOLTO; else if cnt==DEBOUNCE_CYCLES-1 go to PRESSIONADO; else cnt+1.
REQ-015 SHALL mirror REQ-013/014 for release: PRESSIONADO->CONF_SOLTA (cnt=0) on s[i]=0; CONF_SOLTA returns to PRESSIONADO on s[i]=1, reaches SOLTO at cnt==DEBOUNCE_CYCLES-1.
REQ-016 SHALL drive botoes_estavel[i]=1 exactly in states PRESSIONADO and CONF_SOLTA.
REQ-017 SHALL raise a candidate press on the clock edge at which CONF_PRESS->PRESSIONADO; releases SHALL never generate pulses.
REQ-018 SHALL, when several candidates occur on the same edge, forward only the lowest-index one; the others are discarded, not deferred.
REQ-019 SHALL register botoes_pulso so that it is high for exactly one cycle, following the edge of REQ-017; total latency from a clean raw rising level to pulse = DEBOUNCE_CYCLES+3 edges.
REQ-020 SHALL force botoes_pulso to 0 and not count while enable=0; FSMs keep tracking, so a press completing while disabled is lost, never replayed.
REQ-021 SHALL increment jogadas by 1 on each forwarded pulse, saturating at 255.
REQ-022 SHALL clear jogadas to 0 on an edge with clear_jogadas=1; clear wins over a simultaneous increment.
REQ-023 SHALL restart counting from 0 on any bounce (reversal of s[i]) during a confirm state.

Reset
REQ-024 SHALL on rst=1, immediately and regardless of clk, set all synchronizer flops 0, all FSMs SOLTO, all counters 0, botoes_pulso=0, botoes_estavel=0, jogadas=0.
REQ-025 SHALL, if a button is held while rst deasserts, treat it as a new press (pulse after DEBOUNCE_CYCLES+3 edges).
REQ-026 SHALL abort any pulse in flight when rst asserts mid-operation; no pulse is emitted for a partially confirmed press.

Verification (DEBOUNCE_CYCLES=4, enable=1 unless stated)
REQ-027 Clean press: botoes_raw[2] 0->1 held -> botoes_pulso=8'h04 for one cycle after edge 7, botoes_estavel[2]=1, jogadas=1.
REQ-028 Bounce: raw[0] toggles 1,0,1 one cycle each then held 1 -> exactly one pulse 8'h01, timed from the final rise; jogadas=1.
REQ-029 Simultaneous: raw[5] and raw[1] rise same cycle -> single pulse 8'h02, no pulse on bit 5, jogadas=1.
REQ-030 Disable: enable=0 during a completed press -> botoes_pulso stays 0, jogadas unchanged; re-enable while held -> still no pulse.
REQ-031 Saturation/clear: 256 presses -> jogadas=255; clear_jogadas coincident with a pulse -> jogadas=0 next cycle.
REQ-032 Reset mid-confirm: rst pulsed at cnt=2 with raw held 1 -> all outputs 0 immediately, pulse appears 7 edges after rst deasserts.
